// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - flash bus, instruction stream and control signals of the fetch unit
interface fetch_unit_if #(
    parameter int ADDR_W      = 24,
    parameter int INSTR_BYTES = 4
);
    logic                     en;
    logic                     flash_cs;
    logic                     flash_re;
    logic                     flash_we;
    logic [ADDR_W-1:0]        flash_addr;
    logic [7:0]               flash_out;
    logic                     instr_valid;
    logic                     instr_ready;
    logic [8*INSTR_BYTES-1:0] instr_data;
    logic [ADDR_W-1:0]        instr_pc;
    logic                     redirect;
    logic [ADDR_W-1:0]        redirect_pc;
    logic                     halted;
    logic                     busy;

    modport master (
        input  en, flash_out, instr_ready, redirect, redirect_pc,
        output flash_cs, flash_re, flash_we, flash_addr,
        output instr_valid, instr_data, instr_pc, halted, busy
    );

    modport slave (
        output en, flash_out, instr_ready, redirect, redirect_pc,
        input  flash_cs, flash_re, flash_we, flash_addr,
        input  instr_valid, instr_data, instr_pc, halted, busy
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - byte-serial flash instruction fetch with prefetch FIFO
// Builds little-endian words from consecutive flash bytes and queues them with their PCs.
module fetch_unit #(
    parameter int                       ADDR_W      = 24,
    parameter int                       INSTR_BYTES = 4,
    parameter int                       DEPTH       = 4,
    parameter int                       RD_LAT      = 3,
    parameter logic [ADDR_W-1:0]        RESET_PC    = '0,
    parameter logic [8*INSTR_BYTES-1:0] HALT_WORD   = '0
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int W     = 8 * INSTR_BYTES;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BI_W  = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic {IDLE, READ} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] word_pc_q, word_pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] head_pc_q, head_pc_d;
    logic [BI_W-1:0]   byte_idx_q, byte_idx_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [W-1:0]      word_q, word_d;
    logic [W-1:0]      head_data_q, head_data_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_pop;
    logic              halted_q, halted_d;
    logic              cs_q, cs_d;
    logic              valid_q, valid_d;

    logic [W-1:0]      push_word;
    logic [ADDR_W-1:0] push_pc;
    logic              push, pop, start_ok, sample, last_byte, is_halt;

    logic [W-1:0]      mem_data_q [DEPTH];
    logic [ADDR_W-1:0] mem_pc_q   [DEPTH];

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        word_pc_d   = word_pc_q;
        byte_idx_d  = byte_idx_q;
        lat_d       = lat_q;
        word_d      = word_q;
        halted_d    = halted_q;
        head_data_d = head_data_q;
        head_pc_d   = head_pc_q;
        push        = 1'b0;

        pop       = valid_q && bus.instr_ready && !bus.redirect;
        cnt_pop   = cnt_q - CNT_W'(pop);
        start_ok  = bus.en && !halted_q && (cnt_pop < CNT_W'(DEPTH));
        sample    = (state_q == READ) && (lat_q == LAT_W'(RD_LAT - 1));
        last_byte = (byte_idx_q == BI_W'(INSTR_BYTES - 1));

        push_word = word_q;
        push_word[{byte_idx_q, 3'b000} +: 8] = bus.flash_out;
        push_pc   = (byte_idx_q == '0) ? fetch_pc_q : word_pc_q;
        is_halt   = (push_word == HALT_WORD);

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = READ;
                    lat_d   = '0;
                end
            end
            READ: begin
                if (!sample) begin
                    lat_d = lat_q + 1'b1;
                end else begin
                    lat_d      = '0;
                    word_d     = push_word;
                    fetch_pc_d = fetch_pc_q + 1'b1;
                    if (byte_idx_q == '0)
                        word_pc_d = fetch_pc_q;
                    if (last_byte) begin
                        push       = 1'b1;
                        byte_idx_d = '0;
                        halted_d   = is_halt;
                        // The slot just filled counts toward the room check for the next word.
                        if (!bus.en || is_halt || ((cnt_pop + 1'b1) >= CNT_W'(DEPTH)))
                            state_d = IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        cnt_d    = cnt_pop + CNT_W'(push);

        if (bus.redirect) begin
            state_d    = IDLE;
            fetch_pc_d = bus.redirect_pc;
            byte_idx_d = '0;
            lat_d      = '0;
            halted_d   = 1'b0;
            push       = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            cnt_d      = '0;
        end

        valid_d = (cnt_d != '0);
        // The head register tracks the next FIFO head; a push into an emptying FIFO bypasses memory.
        if (valid_d) begin
            if (push && (rd_ptr_d == wr_ptr_q)) begin
                head_data_d = push_word;
                head_pc_d   = push_pc;
            end else begin
                head_data_d = mem_data_q[rd_ptr_d];
                head_pc_d   = mem_pc_q[rd_ptr_d];
            end
        end

        cs_d   = (state_d == READ);
        addr_d = cs_d ? fetch_pc_d : addr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            word_pc_q   <= '0;
            addr_q      <= '0;
            head_pc_q   <= '0;
            byte_idx_q  <= '0;
            lat_q       <= '0;
            word_q      <= '0;
            head_data_q <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            halted_q    <= 1'b0;
            cs_q        <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            word_pc_q   <= word_pc_d;
            addr_q      <= addr_d;
            head_pc_q   <= head_pc_d;
            byte_idx_q  <= byte_idx_d;
            lat_q       <= lat_d;
            word_q      <= word_d;
            head_data_q <= head_data_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            halted_q    <= halted_d;
            cs_q        <= cs_d;
            valid_q     <= valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_pc_q[i]   <= '0;
            end
        end else if (push) begin
            mem_data_q[wr_ptr_q] <= push_word;
            mem_pc_q[wr_ptr_q]   <= push_pc;
        end
    end

    assign bus.flash_cs    = cs_q;
    assign bus.flash_re    = cs_q;
    assign bus.flash_we    = 1'b0;
    assign bus.flash_addr  = addr_q;
    assign bus.busy        = cs_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr_data  = head_data_q;
    assign bus.instr_pc    = head_pc_q;
    assign bus.halted      = halted_q;
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction fetch unit between the byte-wide `flash` and the control path. It generalises the byte-serial fetch sequence into synthesizable hardware, with configurable instruction width, flash read latency and a prefetch FIFO. It assembles little-endian instruction words from consecutive flash bytes and queues them with their PCs behind a valid/ready handshake. It also supports branch redirect/flush and halt-instruction detection.

## Interface
- `ADDR_W`, 24, flash/PC address width
- `INSTR_BYTES`, 4, bytes per instruction (≥1)
- `DEPTH`, 4, prefetch FIFO entries (power of 2, ≥2)
- `RD_LAT`, 3, flash read latency in cycles (≥1)
- `RESET_PC`, 0, fetch address after reset
- `HALT_WORD`, 0, instruction value that stops prefetch

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-low
- `en` in 1: fetch enable
- `flash_cs` out 1: flash chip select
- `flash_re` out 1: flash read enable
- `flash_we` out 1: flash write enable, constant 0
- `flash_addr` out ADDR_W: flash byte address
- `flash_out` in 8: flash read data
- `instr_valid` out 1: FIFO head valid
- `instr_ready` in 1: consumer accepts head
- `instr_data` out 8*INSTR_BYTES: head instruction
- `instr_pc` out ADDR_W: address of head's byte 0
- `redirect` in 1: flush and restart fetch
- `redirect_pc` in ADDR_W: new fetch address
- `halted` out 1: HALT_WORD fetched, prefetch stopped
- `busy` out 1: a flash read is in progress

## Operation
- FSM states: IDLE and READ.
- IDLE→READ at an edge where `en`=1, `halted`=0, `redirect`=0 and FIFO count < DEPTH.
- READ: `flash_cs`=`flash_re`=1 and `flash_addr`=`fetch_pc`, held stable for RD_LAT cycles. `flash_out` is sampled at the last edge of that window.
- The sampled byte goes to lane `byte_idx` (byte 0 → bits [7:0]). `fetch_pc` increments mod 2^ADDR_W and `byte_idx` increments.
- After the last byte: the word and its start PC are pushed into the FIFO and `byte_idx` returns to 0.
- After a push, the FSM stays in READ if the IDLE→READ condition holds (counting that push); otherwise it goes to IDLE.
- Only one instruction is in flight, and a start needs count < DEPTH, so a push never overflows.
- `en`=0 mid-instruction: the current instruction completes and is pushed, then the FSM goes to IDLE.
- Halt: a pushed word equal to HALT_WORD is queued normally, then `halted`=1 and the FSM goes to IDLE. `halted` clears only on `redirect`.
- Redirect (highest priority, synchronous): empties the FIFO, discards any partial word, sets `fetch_pc`=`redirect_pc` and clears `halted`. The FSM goes to IDLE and the next cycle has `flash_cs`=0.
- Pop: `instr_valid` & `instr_ready` at an edge. Push and pop at the same edge leave count unchanged. A pop at the same edge as `redirect` is ignored (flush wins).
- `instr_data`/`instr_pc` are stable while `instr_valid` & !`instr_ready`.
- An instruction may straddle the address wrap: byte 0 at 2^ADDR_W−1, byte 1 at 0.

## Timing
- Reset values: `flash_cs`=`flash_re`=`flash_we`=0, `flash_addr`=0, `instr_valid`=0, `instr_data`=0, `instr_pc`=0, `halted`=0, `busy`=0; internal `fetch_pc`=RESET_PC, FIFO empty, `byte_idx`=0.
- Reset asserted mid-read clears all state immediately, with no flash access after it.
- All outputs are registered; `busy` equals `flash_cs`.
- With `en`=1 in cycle 0, `flash_cs` rises in cycle 1. Byte k is sampled at the end of cycle (k+1)·RD_LAT.
- `instr_valid` rises in cycle INSTR_BYTES·RD_LAT+1 (13 with defaults).
- Sustained throughput: one instruction per INSTR_BYTES·RD_LAT cycles, with no gap cycles between bytes or instructions.
- Redirect at edge t: `flash_cs`=0 and `instr_valid`=0 in cycle t+1. New fetch starts with `flash_cs`=1 in cycle t+2 if enabled.

## Test plan
- Flash holds 0x02000283 at address 0; `en`=1, `instr_ready`=1 → `instr_data`=0x02000283 and `instr_pc`=0 valid in cycle 13; `flash_addr` steps 0,1,2,3, each held 3 cycles.
- Five sequential words, `instr_ready`=0 → exactly 4 words queued, `flash_cs`=0 while full. Pop one → fetch resumes and the 5th word has `instr_pc`=0x10.
- Program 0x02000283, 0x006283B3, 0x00000000 → three words delivered in order, `halted`=1, no flash access to address 0x0C.
- `redirect` with `redirect_pc`=0x20 during byte 2 of a fetch, with 2 words queued → FIFO empty next cycle, partial word dropped, next delivered `instr_pc`=0x20.
- RESET_PC=0xFFFFFE, INSTR_BYTES=4 → `flash_addr` sequence FFFFFE, FFFFFF, 000000, 000001, and `instr_pc`=0xFFFFFE.
- `rst` low in the middle of a read → `flash_cs`=0 and `instr_valid`=0 immediately. After release, fetch restarts at RESET_PC.
